os_framer: RTL

OS_FRAMER -- requirements
Module: os_framer

---
 rtl/os_pkg.sv | 20 ++
 rtl/cplx_ring_buf.sv | 33 +++
 rtl/os_framer.sv | 114 +++++++++++
 3 files changed

// File: rtl/os_pkg.sv
// Shared definitions for the overlap-save framer.
//   state_t    : framer FSM states (S_FILL collects samples, S_SEND streams a frame)
//   ptr_width  : width of the circular-buffer pointers (wraps modulo 2*NFFT)
//   half_len   : overlap / hop size H = NFFT/2
package os_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_SEND = 1'b1
    } state_t;

    function automatic int ptr_width(input int logn);
        return logn + 1;
    endfunction

    function automatic int half_len(input int nfft);
        return nfft / 2;
    endfunction

endpackage

// File: rtl/cplx_ring_buf.sv
// Complex sample storage for the framer: 2**AW entries of DW bits.
//   i_clk, i_rst_n : clock, asynchronous active-low clear of every entry
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous (combinational) read port
module cplx_ring_buf #(
    parameter int AW = 6,
    parameter int DW = 18
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: every entry is cleared on reset because the first frame relies on
    // the H slots ahead of the write pointer reading back as zero; this makes
    // the array flops rather than a RAM macro.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/os_framer.sv
// Overlap-save framer: turns a continuous I/Q stream into NFFT-sample frames
// that overlap by H = NFFT/2 (frame k = samples k*H-H .. k*H+H-1, negative
// indices read as zero), streamed to an FFT with valid/ready flow control.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_valid, i_xI, i_xQ   : upstream samples; o_ready says a sample is taken
//   o_valid, o_xI, o_xQ   : frame samples to the FFT; i_ready is its accept
//   o_start               : marks the first sample of each frame
//   o_overflow            : sticky, set when a sample arrived while !o_ready
module os_framer
    import os_pkg::*;
#(
    parameter int NFFT  = 32,
    parameter int LOGN  = 5,
    parameter int NB_IN = 9
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic signed [NB_IN-1:0] i_xI,
    input  logic signed [NB_IN-1:0] i_xQ,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic signed [NB_IN-1:0] o_xI,
    output logic signed [NB_IN-1:0] o_xQ,
    input  logic                    i_ready,
    output logic                    o_start,
    output logic                    o_overflow
);

    localparam int H  = half_len(NFFT);
    localparam int PW = ptr_width(LOGN);

    localparam logic [PW:0]     LVL_FULL = (PW+1)'(2 * NFFT);
    localparam logic [PW:0]     LVL_N    = (PW+1)'(NFFT);
    localparam logic [PW:0]     LVL_H    = (PW+1)'(H);
    localparam logic [PW-1:0]   PTR_H    = PW'(H);
    localparam logic [LOGN-1:0] IDX_LAST = LOGN'(NFFT - 1);

    state_t          state;
    logic [PW-1:0]   wr;
    logic [PW-1:0]   base;
    logic            full;
    logic [LOGN-1:0] rd_idx;

    logic [PW:0]         level;
    logic [PW:0]         level_nxt;
    logic                accept;
    logic                handshake;
    logic                retire;
    logic [2*NB_IN-1:0]  rdata;

    // wr == base is ambiguous (empty or all 2*NFFT slots used); full resolves it.
    assign level     = full ? LVL_FULL : {1'b0, wr - base};
    assign o_ready   = (level < LVL_FULL);
    assign accept    = i_valid && o_ready;
    assign o_valid   = (state == S_SEND);
    assign handshake = o_valid && i_ready;
    assign retire    = handshake && (rd_idx == IDX_LAST);
    assign o_start   = o_valid && (rd_idx == '0);

    // Level after this edge's write and retire; both may happen together.
    assign level_nxt = level + (PW+1)'(accept) - (retire ? LVL_H : '0);

    cplx_ring_buf #(
        .AW (PW),
        .DW (2 * NB_IN)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .we      (accept),
        .waddr   (wr),
        .wdata   ({i_xI, i_xQ}),
        .raddr   (base + PW'(rd_idx)),
        .rdata   (rdata)
    );

    assign o_xI = o_valid ? signed'(rdata[2*NB_IN-1:NB_IN]) : '0;
    assign o_xQ = o_valid ? signed'(rdata[NB_IN-1:0])       : '0;

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_FILL;
            base       <= '0;
            // Starting H ahead of base makes the zeroed slots the leading
            // half of frame 0.
            wr         <= PTR_H;
            full       <= 1'b0;
            rd_idx     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (accept)              wr         <= wr + 1'b1;
            if (i_valid && !o_ready) o_overflow <= 1'b1;
            full <= (level_nxt == LVL_FULL);

            case (state)
                S_FILL: begin
                    if (level_nxt >= LVL_N) state <= S_SEND;
                end
                S_SEND: begin
                    if (handshake) rd_idx <= rd_idx + 1'b1;
                    if (retire) begin
                        rd_idx <= '0;
                        base   <= base + PTR_H;
                        if (level_nxt < LVL_N) state <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule
